// File: rtl/mem_rw_sched_pkg.sv
// Shared memory-controller definitions: scheduler state encoding, rd_run width
// and the default burst address width.
package mem_rw_sched_pkg;

  localparam int unsigned MemAddrBits = 25;
  localparam int unsigned RdRunBits   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StGap
  } sched_state_e;

  typedef logic [RdRunBits-1:0] rd_run_t;

endpackage

// File: rtl/mem_rw_sched.sv
// Read/write burst scheduler: arbitrates two burst requesters onto one burst engine,
// with read priority bounded by a run counter while a write is waiting.
module mem_rw_sched
  import mem_rw_sched_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = MemAddrBits,
  parameter int unsigned RD_MAX_RUN = 4
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  input  logic                 local_init_done,
  input  logic                 rd_burst_req,
  input  logic [9:0]           rd_burst_len,
  input  logic [ADDR_BITS-1:0] rd_burst_addr,
  output logic                 rd_burst_finish,
  input  logic                 wr_burst_req,
  input  logic [9:0]           wr_burst_len,
  input  logic [ADDR_BITS-1:0] wr_burst_addr,
  output logic                 wr_burst_finish,
  output logic                 eng_burst_req,
  output logic                 eng_burst_wr,
  output logic [9:0]           eng_burst_len,
  output logic [ADDR_BITS-1:0] eng_burst_addr,
  input  logic                 eng_burst_finish,
  output logic                 busy
);

  localparam rd_run_t RdRunMax = rd_run_t'(RD_MAX_RUN);
  localparam rd_run_t RdRunSat = '1;

  sched_state_e         state_q, state_d;
  rd_run_t              rd_run_q, rd_run_d;
  logic [9:0]           len_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 rd_finish_q, wr_finish_q;
  logic                 grant_rd, grant_wr;
  logic                 zero_len, burst_done;

  assign zero_len   = (len_q == '0);
  // A zero-length burst never reaches the engine, so it completes on its own.
  assign burst_done = zero_len || eng_burst_finish;

  // Arbitration: only meaningful in IDLE once memory init has completed.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    rd_run_d = rd_run_q;
    if (state_q == StIdle && local_init_done) begin
      if (rd_burst_req && wr_burst_req) begin
        if (rd_run_q >= RdRunMax) begin
          grant_wr = 1'b1;
        end else begin
          grant_rd = 1'b1;
        end
      end else begin
        grant_rd = rd_burst_req;
        grant_wr = wr_burst_req;
      end
    end
    if (grant_wr) begin
      rd_run_d = '0;
    end else if (grant_rd) begin
      if (wr_burst_req) begin
        rd_run_d = (rd_run_q == RdRunSat) ? rd_run_q : rd_run_q + 1'b1;
      end else begin
        rd_run_d = '0;
      end
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_rd) begin
          state_d = StRd;
        end else if (grant_wr) begin
          state_d = StWr;
        end
      end
      StRd, StWr: begin
        if (burst_done) begin
          state_d = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      rd_run_q    <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      rd_finish_q <= 1'b0;
      wr_finish_q <= 1'b0;
    end else begin
      rd_run_q <= rd_run_d;
      if (grant_rd) begin
        len_q  <= rd_burst_len;
        addr_q <= rd_burst_addr;
      end else if (grant_wr) begin
        len_q  <= wr_burst_len;
        addr_q <= wr_burst_addr;
      end
      rd_finish_q <= (state_q == StRd) && burst_done;
      wr_finish_q <= (state_q == StWr) && burst_done;
    end
  end

  always_comb begin
    busy          = (state_q != StIdle);
    eng_burst_req = (state_q == StRd || state_q == StWr) && !zero_len;
    eng_burst_wr  = (state_q == StWr);
  end

  assign eng_burst_len   = len_q;
  assign eng_burst_addr  = addr_q;
  assign rd_burst_finish = rd_finish_q;
  assign wr_burst_finish = wr_finish_q;

endmodule

// File: tb/tb_mem_rw_sched.sv
// Self-checking bench for mem_rw_sched: directed vector table, hand sequences for
// init/reset/spurious-finish corners, and a randomized run against a transaction model.
module tb_mem_rw_sched;

  localparam int unsigned AddrBits = 25;
  localparam int unsigned RdMaxRun = 4;

  logic                mem_clk = 1'b0;
  logic                rst, local_init_done;
  logic                rd_burst_req, wr_burst_req, eng_burst_finish;
  logic [9:0]          rd_burst_len, wr_burst_len, eng_burst_len;
  logic [AddrBits-1:0] rd_burst_addr, wr_burst_addr, eng_burst_addr;
  logic                rd_burst_finish, wr_burst_finish;
  logic                eng_burst_req, eng_burst_wr, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 mem_clk = ~mem_clk;

  mem_rw_sched #(
    .ADDR_BITS  (AddrBits),
    .RD_MAX_RUN (RdMaxRun)
  ) dut (
    .mem_clk          (mem_clk),
    .rst              (rst),
    .local_init_done  (local_init_done),
    .rd_burst_req     (rd_burst_req),
    .rd_burst_len     (rd_burst_len),
    .rd_burst_addr    (rd_burst_addr),
    .rd_burst_finish  (rd_burst_finish),
    .wr_burst_req     (wr_burst_req),
    .wr_burst_len     (wr_burst_len),
    .wr_burst_addr    (wr_burst_addr),
    .wr_burst_finish  (wr_burst_finish),
    .eng_burst_req    (eng_burst_req),
    .eng_burst_wr     (eng_burst_wr),
    .eng_burst_len    (eng_burst_len),
    .eng_burst_addr   (eng_burst_addr),
    .eng_burst_finish (eng_burst_finish),
    .busy             (busy)
  );

  typedef struct {
    logic                rd_req;
    logic                wr_req;
    logic [9:0]          rd_len;
    logic [9:0]          wr_len;
    logic [AddrBits-1:0] rd_addr;
    logic [AddrBits-1:0] wr_addr;
    logic                exp_wr;
    logic [9:0]          exp_len;
    logic [AddrBits-1:0] exp_addr;
    logic                exp_req;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called one cycle after the grant edge.
  task automatic check_grant(input string tag, input logic exp_wr, input logic [9:0] len,
                             input logic [AddrBits-1:0] addr);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " eng_wr"}, 32'(eng_burst_wr), 32'(exp_wr));
    chk({tag, " eng_len"}, 32'(eng_burst_len), 32'(len));
    chk({tag, " eng_addr"}, 32'(eng_burst_addr), 32'(addr));
    chk({tag, " eng_req"}, 32'(eng_burst_req), 32'(len != 10'd0));
    chk({tag, " no fin"}, 32'({rd_burst_finish, wr_burst_finish}), 32'd0);
  endtask

  // Runs the engine side of a granted burst through GAP back to IDLE.
  task automatic complete(input string tag, input logic exp_wr, input logic [9:0] len,
                          input int unsigned hold, input logic spurious);
    if (len != 10'd0) begin
      for (int i = 0; i < int'(hold); i++) begin
        tick();
        chk({tag, " hold eng_req"}, 32'(eng_burst_req), 32'd1);
        chk({tag, " early fin"}, 32'({rd_burst_finish, wr_burst_finish}), 32'd0);
      end
      eng_burst_finish = 1'b1;
      tick();
      eng_burst_finish = 1'b0;
    end else begin
      tick();
    end
    chk({tag, " rd_fin"}, 32'(rd_burst_finish), 32'(!exp_wr));
    chk({tag, " wr_fin"}, 32'(wr_burst_finish), 32'(exp_wr));
    chk({tag, " gap eng_req"}, 32'(eng_burst_req), 32'd0);
    chk({tag, " gap busy"}, 32'(busy), 32'd1);
    if (exp_wr) wr_burst_req = 1'b0;
    else        rd_burst_req = 1'b0;
    eng_burst_finish = spurious;
    tick();
    eng_burst_finish = 1'b0;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " fin width"}, 32'({rd_burst_finish, wr_burst_finish}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic                gw;
    logic                rd_pend, wr_pend;
    logic [9:0]          rlen, wlen;
    logic [AddrBits-1:0] raddr, waddr;
    int                  streak;

    vecs[0]  = '{1'b1, 1'b0, 10'd16, 10'd0, 25'h100, 25'h0, 1'b0, 10'd16, 25'h100, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 10'd0, 10'd8, 25'h0, 25'h2000, 1'b1, 10'd8, 25'h2000, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 10'd3, 10'd5, 25'h10, 25'h20, 1'b0, 10'd3, 25'h10, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 10'd3, 10'd5, 25'h10, 25'h20, 1'b0, 10'd3, 25'h10, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 10'd3, 10'd5, 25'h10, 25'h20, 1'b0, 10'd3, 25'h10, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 10'd3, 10'd5, 25'h10, 25'h20, 1'b0, 10'd3, 25'h10, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 10'd3, 10'd5, 25'h10, 25'h20, 1'b1, 10'd5, 25'h20, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 10'd3, 10'd5, 25'h10, 25'h20, 1'b0, 10'd3, 25'h10, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 10'd9, 10'd0, 25'h7, 25'h333, 1'b1, 10'd0, 25'h333, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 10'd0, 10'd9, 25'h44, 25'h7, 1'b0, 10'd0, 25'h44, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 10'd1023, 10'd7, 25'h1FFFFFF, 25'h55, 1'b0, 10'd1023,
                 25'h1FFFFFF, 1'b1};

    // Reset with both requests up and init not done.
    rst = 1'b1;
    local_init_done = 1'b0;
    eng_burst_finish = 1'b0;
    rd_burst_req = 1'b1;  rd_burst_len = 10'd4;  rd_burst_addr = 25'h40;
    wr_burst_req = 1'b1;  wr_burst_len = 10'd4;  wr_burst_addr = 25'h80;
    tick();
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst eng_req", 32'(eng_burst_req), 32'd0);
    chk("rst eng_wr", 32'(eng_burst_wr), 32'd0);
    chk("rst fin", 32'({rd_burst_finish, wr_burst_finish}), 32'd0);
    chk("rst eng_len", 32'(eng_burst_len), 32'd0);
    chk("rst eng_addr", 32'(eng_burst_addr), 32'd0);

    // No grant while init is pending; read wins the first grant afterwards.
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("init busy", 32'(busy), 32'd0);
      chk("init eng_req", 32'(eng_burst_req), 32'd0);
    end
    local_init_done = 1'b1;
    tick();
    check_grant("init grant", 1'b0, 10'd4, 25'h40);
    complete("init", 1'b0, 10'd4, 2, 1'b0);

    // Directed vectors; the 'both' rows walk the read-run limit.
    for (int v = 0; v < 11; v++) begin
      rd_burst_req = vecs[v].rd_req;  rd_burst_len = vecs[v].rd_len;
      rd_burst_addr = vecs[v].rd_addr;
      wr_burst_req = vecs[v].wr_req;  wr_burst_len = vecs[v].wr_len;
      wr_burst_addr = vecs[v].wr_addr;
      tick();
      check_grant($sformatf("vec%0d", v), vecs[v].exp_wr, vecs[v].exp_len, vecs[v].exp_addr);
      chk($sformatf("vec%0d eng_req", v), 32'(eng_burst_req), 32'(vecs[v].exp_req));
      complete($sformatf("vec%0d", v), vecs[v].exp_wr, vecs[v].exp_len, 1, 1'b0);
    end
    rd_burst_req = 1'b0;
    wr_burst_req = 1'b0;

    // Long read: engine finishes 20 cycles after the grant; inputs change mid-burst.
    rd_burst_req = 1'b1;  rd_burst_len = 10'd16;  rd_burst_addr = 25'h100;
    tick();
    check_grant("rd20", 1'b0, 10'd16, 25'h100);
    rd_burst_len = 10'd99;
    rd_burst_addr = 25'hABC;
    complete("rd20", 1'b0, 10'd16, 19, 1'b0);
    chk("rd20 latched len", 32'(eng_burst_len), 32'd16);

    // Spurious engine finish in IDLE.
    eng_burst_finish = 1'b1;
    tick();
    eng_burst_finish = 1'b0;
    chk("spur busy", 32'(busy), 32'd0);
    chk("spur fin", 32'({rd_burst_finish, wr_burst_finish}), 32'd0);
    chk("spur eng_req", 32'(eng_burst_req), 32'd0);
    tick();
    chk("spur busy2", 32'(busy), 32'd0);

    // Reset in the middle of a write; the held write is granted again afterwards.
    wr_burst_req = 1'b1;  wr_burst_len = 10'd12;  wr_burst_addr = 25'h1234;
    tick();
    check_grant("rstwr", 1'b1, 10'd12, 25'h1234);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstwr eng_req", 32'(eng_burst_req), 32'd0);
    chk("rstwr busy", 32'(busy), 32'd0);
    chk("rstwr fin", 32'(wr_burst_finish), 32'd0);
    chk("rstwr len", 32'(eng_burst_len), 32'd0);
    tick();
    chk("rstwr no late fin", 32'(wr_burst_finish), 32'd0);
    check_grant("rstwr regrant", 1'b1, 10'd12, 25'h1234);
    complete("rstwr", 1'b1, 10'd12, 3, 1'b0);

    // Randomized traffic against a transaction-level arbitration model.
    rd_pend = 1'b0;  wr_pend = 1'b0;  streak = 0;
    rlen = '0;  wlen = '0;  raddr = '0;  waddr = '0;
    for (int t = 0; t < 250; t++) begin
      if (!rd_pend && !wr_pend && $urandom_range(0, 2) == 0) begin
        eng_burst_finish = 1'($urandom_range(0, 1));
        tick();
        eng_burst_finish = 1'b0;
        chk("rand idle busy", 32'(busy), 32'd0);
        chk("rand idle fin", 32'({rd_burst_finish, wr_burst_finish}), 32'd0);
      end
      if (!rd_pend && $urandom_range(0, 1) == 1) rd_pend = 1'b1;
      if (!wr_pend && $urandom_range(0, 1) == 1) wr_pend = 1'b1;
      if (!rd_pend && !wr_pend) begin
        if ($urandom_range(0, 1) == 1) rd_pend = 1'b1;
        else                           wr_pend = 1'b1;
      end
      if (rd_pend && !rd_burst_req) begin
        rlen  = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        raddr = AddrBits'($urandom);
        rd_burst_req = 1'b1;  rd_burst_len = rlen;  rd_burst_addr = raddr;
      end
      if (wr_pend && !wr_burst_req) begin
        wlen  = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        waddr = AddrBits'($urandom);
        wr_burst_req = 1'b1;  wr_burst_len = wlen;  wr_burst_addr = waddr;
      end
      gw = wr_pend && (!rd_pend || streak >= int'(RdMaxRun));
      if (gw)           streak = 0;
      else if (wr_pend) streak = (streak < 15) ? streak + 1 : 15;
      else              streak = 0;
      tick();
      check_grant($sformatf("rand%0d", t), gw, gw ? wlen : rlen, gw ? waddr : raddr);
      if (gw) begin
        wr_burst_len = 10'($urandom);  wr_burst_addr = AddrBits'($urandom);
      end else begin
        rd_burst_len = 10'($urandom);  rd_burst_addr = AddrBits'($urandom);
      end
      complete($sformatf("rand%0d", t), gw, gw ? wlen : rlen, $urandom_range(0, 4),
               1'($urandom_range(0, 1)));
      if (gw) wr_pend = 1'b0;
      else    rd_pend = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rw_sched.md
MEM_RW_SCHED -- requirements
Module: mem_rw_sched

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 25, meaning burst address width.
REQ-002 SHALL have parameter RD_MAX_RUN, default 4, meaning max consecutive read grants while a write is pending (range 1-15).
REQ-003 SHALL have ports (one clock; reset is synchronous and active-high):
- mem_clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- local_init_done  in  1  memory init complete; no grant while low
- rd_burst_req  in  1  read request, level, held until rd_burst_finish
- rd_burst_len  in  10  read length in words
- rd_burst_addr  in  ADDR_BITS  read start address
- rd_burst_finish  out  1  one-cycle read completion pulse
- wr_burst_req  in  1  write request, level, held until wr_burst_finish
- wr_burst_len  in  10  write length in words
- wr_burst_addr  in  ADDR_BITS  write start address
- wr_burst_finish  out  1  one-cycle write completion pulse
- eng_burst_req  out  1  request to burst engine, level
- eng_burst_wr  out  1  1 = write, 0 = read; valid while eng_burst_req
- eng_burst_len  out  10  latched length
- eng_burst_addr  out  ADDR_BITS  latched address
- eng_burst_finish  in  1  engine completion pulse
- busy  out  1  high in any state except IDLE

Function
REQ-004 SHALL implement states IDLE, RD, WR, GAP.
REQ-005 In IDLE with local_init_done=1, SHALL sample requests and grant one, moving to RD or WR on the next edge; with local_init_done=0, SHALL remain in IDLE.
REQ-006 With only one request, SHALL grant it.
REQ-007 With both requests pending, SHALL grant read unless rd_run >= RD_MAX_RUN, in which case write SHALL be granted.
REQ-008 rd_run SHALL be a 4-bit counter that increments on a read grant made while wr_burst_req=1 and saturates at 15.
REQ-009 rd_run SHALL clear on any write grant and on any read grant made while wr_burst_req=0.
REQ-010 SHALL latch len/addr of the granted side into eng_burst_len/eng_burst_addr on the grant edge; later input changes SHALL be ignored until the next grant.
REQ-011 eng_burst_req SHALL be 1 in RD/WR from the cycle after grant until the cycle eng_burst_finish=1 is sampled, inclusive.
REQ-012 eng_burst_wr SHALL be 1 in WR and 0 otherwise.
REQ-013 On eng_burst_finish in RD, rd_burst_finish SHALL pulse exactly one cycle (registered, next cycle) and the FSM SHALL go to GAP; WR likewise with wr_burst_finish.
REQ-014 GAP SHALL last exactly one cycle, then return to IDLE, so a requester's dropped req is never re-granted.
REQ-015 A granted burst with len=0 SHALL NOT assert eng_burst_req; SHALL pulse the matching finish on the cycle after grant and go to GAP.
REQ-016 eng_burst_finish in IDLE or GAP SHALL be ignored.
REQ-017 Request deassertion during RD/WR SHALL NOT abort the burst.
REQ-018 Latency: request seen in IDLE -> eng_burst_req high 1 cycle later; eng_burst_finish -> requester finish 1 cycle later; minimum back-to-back grant spacing: finish + GAP + IDLE.

Reset
REQ-019 rst=1 SHALL force state IDLE, rd_run=0, and eng_burst_req, eng_burst_wr, rd_burst_finish, wr_burst_finish, busy to 0; eng_burst_len/addr to 0.
REQ-020 rst asserted mid-burst SHALL drop eng_burst_req the next cycle with no finish pulse issued.

Structure
REQ-021 State encodings and the rd_run width SHALL reside in the shared memory-controller package; ADDR_BITS default SHALL match it.
REQ-022 SHALL be a single module with no sub-modules; the arbitration decision SHALL be a separate combinational process feeding the FSM.

Verification
REQ-023 Read only: rd req, len=16, addr=0x100; engine finish after 20 cycles -> eng_burst_req 1 cycle after req, wr=0, len=16, addr=0x100; rd_burst_finish 1-cycle pulse; busy falls after GAP.
REQ-024 Both held, RD_MAX_RUN=4, rd re-requests after each finish -> grant order R,R,R,R,W,R; rd_run 0 after W.
REQ-025 len=0 write -> no eng_burst_req; wr_burst_finish pulses 2 cycles after req.
REQ-026 local_init_done=0 for 50 cycles with both reqs -> no grant; first grant = read 1 cycle after init_done rises.
REQ-027 rst=1 during a WR burst -> eng_burst_req 0 next cycle; no wr_burst_finish; after release the pending write is re-granted.
REQ-028 Spurious eng_burst_finish in IDLE -> no finish outputs; state unchanged.
